// File: rtl/bsg_demuxi2_buffered_pkg.sv
// Shared constants for the buffered inverting 1:2 demultiplexer.
//   NumChannels : number of output channels fed by the demux
//   FifoDepth   : entries held by each per-channel output buffer
package bsg_demuxi2_buffered_pkg;

    localparam int unsigned NumChannels = 2;
    localparam int unsigned FifoDepth   = 2;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry in-order FIFO with valid/ready enqueue and valid/yumi dequeue.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset (clears occupancy)
//   data_i, v_i    : enqueue word and valid; the word is taken when v_i & ready_o
//   ready_o        : at least one free slot (registered state only)
//   data_o, v_o    : oldest stored word and its valid (count != 0)
//   yumi_i         : consumer takes the head this cycle; only legal while v_o
module bsg_two_fifo
    import bsg_demuxi2_buffered_pkg::*;
#(
    parameter int unsigned width_p = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, wr_ptr_q;
    logic [width_p-1:0] mem_q [2];
    logic               enq, deq;

    assign ready_o = (count_q != 2'(FifoDepth));
    assign v_o     = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    assign enq = v_i & ready_o;
    // Gating with v_o keeps state unchanged on an illegal yumi.
    assign deq = yumi_i & v_o;

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (enq) wr_ptr_q <= ~wr_ptr_q;
            if (deq) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq) mem_q[wr_ptr_q] <= data_i;
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("bsg_two_fifo: yumi_i asserted while v_o is low");

endmodule

// File: rtl/bsg_demuxi2_buffered.sv
// Streaming 1:2 demultiplexer with optional bit inversion and a 2-entry buffer per output.
// Ports:
//   clk_i, reset_i     : clock, synchronous active-high reset (discards buffered words)
//   data_i, sel_i, v_i : input word, destination channel, valid
//   ready_o            : both channel buffers have a free slot and reset_i is low
//   data0_o, v0_o      : channel 0 head word and valid; yumi0_i consumes it
//   data1_o, v1_o      : channel 1 head word and valid; yumi1_i consumes it
module bsg_demuxi2_buffered
    import bsg_demuxi2_buffered_pkg::*;
#(
    parameter int unsigned width_p  = 5,
    parameter bit          invert_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               sel_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data0_o,
    output logic               v0_o,
    input  logic               yumi0_i,
    output logic [width_p-1:0] data1_o,
    output logic               v1_o,
    input  logic               yumi1_i
);

    logic [NumChannels-1:0] fifo_ready;
    logic [NumChannels-1:0] fifo_v_in;
    logic [width_p-1:0]     data_stored;

    // Restores true polarity after an upstream inverting mux stage.
    assign data_stored = invert_p ? ~data_i : data_i;

    // Conservative: a full buffer on either side stalls the input regardless of sel_i.
    assign ready_o = ~reset_i & (&fifo_ready);

    assign fifo_v_in[0] = v_i & ready_o & (sel_i == 1'b0);
    assign fifo_v_in[1] = v_i & ready_o & (sel_i == 1'b1);

    bsg_two_fifo #(
        .width_p (width_p)
    ) u_fifo0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_stored),
        .v_i     (fifo_v_in[0]),
        .ready_o (fifo_ready[0]),
        .data_o  (data0_o),
        .v_o     (v0_o),
        .yumi_i  (yumi0_i)
    );

    bsg_two_fifo #(
        .width_p (width_p)
    ) u_fifo1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_stored),
        .v_i     (fifo_v_in[1]),
        .ready_o (fifo_ready[1]),
        .data_o  (data1_o),
        .v_o     (v1_o),
        .yumi_i  (yumi1_i)
    );

    sel_known_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        v_i |-> !$isunknown(sel_i))
        else $error("bsg_demuxi2_buffered: sel_i unknown while v_i is high");

endmodule

// File: tb/tb_bsg_demuxi2_buffered.sv
module tb_bsg_demuxi2_buffered;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [4:0] data_i = '0;
    logic       sel_i = 1'b0, v_i = 1'b0, yumi0_i = 1'b0, yumi1_i = 1'b0;
    logic       ready_o, v0_o, v1_o;
    logic [4:0] data0_o, data1_o;

    // Non-inverting instance
    logic [4:0] ni_data = '0;
    logic       ni_sel = 1'b0, ni_v = 1'b0, ni_yumi0 = 1'b0, ni_yumi1 = 1'b0;
    logic       ni_ready, ni_v0, ni_v1;
    logic [4:0] ni_data0, ni_data1;

    always #5 clk = ~clk;

    bsg_demuxi2_buffered #(.width_p(5), .invert_p(1'b1)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .sel_i(sel_i), .v_i(v_i),
        .ready_o(ready_o), .data0_o(data0_o), .v0_o(v0_o), .yumi0_i(yumi0_i),
        .data1_o(data1_o), .v1_o(v1_o), .yumi1_i(yumi1_i)
    );

    bsg_demuxi2_buffered #(.width_p(5), .invert_p(1'b0)) u_dut_ni (
        .clk_i(clk), .reset_i(reset_i), .data_i(ni_data), .sel_i(ni_sel), .v_i(ni_v),
        .ready_o(ni_ready), .data0_o(ni_data0), .v0_o(ni_v0), .yumi0_i(ni_yumi0),
        .data1_o(ni_data1), .v1_o(ni_v1), .yumi1_i(ni_yumi1)
    );

    typedef struct {
        logic [4:0] data;
        logic       sel, v, y0, y1;
        logic       exp_ready, exp_v0, exp_v1;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] q0[$], q1[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [4:0] d, input logic s, input logic v,
                                input logic y0, input logic y1, input logic er,
                                input logic e0, input logic e1);
        vec_t r;
        r.data = d; r.sel = s; r.v = v; r.y0 = y0; r.y1 = y1;
        r.exp_ready = er; r.exp_v0 = e0; r.exp_v1 = e1;
        tbl.push_back(r);
    endfunction

    // One cycle: drive inputs, record expected transfers, compare consumed heads, advance.
    task automatic drive_cycle(input logic [4:0] d, input logic s, input logic v,
                               input logic y0, input logic y1);
        logic [4:0] exp_w;
        data_i  = d;
        sel_i   = s;
        v_i     = v;
        yumi0_i = y0 & v0_o;
        yumi1_i = y1 & v1_o;
        if (v && ready_o) begin
            if (s) q1.push_back(~d);
            else   q0.push_back(~d);
        end
        if (yumi0_i) begin
            if (q0.size() == 0) check("ch0_unexpected_word", 32'(data0_o), 32'hffff_ffff);
            else begin exp_w = q0.pop_front(); check("ch0_data", 32'(data0_o), 32'(exp_w)); end
        end
        if (yumi1_i) begin
            if (q1.size() == 0) check("ch1_unexpected_word", 32'(data1_o), 32'hffff_ffff);
            else begin exp_w = q1.pop_front(); check("ch1_data", 32'(data1_o), 32'(exp_w)); end
        end
        step();
        v_i     = 1'b0;
        yumi0_i = 1'b0;
        yumi1_i = 1'b0;
    endtask

    initial begin
        // Alternating stream, yumi tied to valid
        add(5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++)
            add(5'(i), 1'(i % 2), 1'b1, 1'b1, 1'b1, 1'b1, 1'(i % 2), 1'(1 - (i % 2)));
        add(5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        add(5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // Backpressure on channel 1
        add(5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        add(5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        add(5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Enqueue + dequeue on channel 0 at count=1
        add(5'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(5'd21, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset
        reset_i = 1'b1;
        step();
        step();
        check("reset_ready", 32'(ready_o), 32'd0);
        check("reset_v0", 32'(v0_o), 32'd0);
        check("reset_v1", 32'(v1_o), 32'd0);
        reset_i = 1'b0;
        #1;
        check("post_reset_ready", 32'(ready_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("idle_ready", 32'(ready_o), 32'd1);
            check("idle_v0", 32'(v0_o), 32'd0);
            check("idle_v1", 32'(v1_o), 32'd0);
            step();
        end

        // Single word with inversion
        drive_cycle(5'b10110, 1'b0, 1'b1, 1'b0, 1'b0);
        check("single_v0", 32'(v0_o), 32'd1);
        check("single_data0", 32'(data0_o), 32'(5'b01001));
        check("single_v1", 32'(v1_o), 32'd0);
        drive_cycle(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("single_v0_after_yumi", 32'(v0_o), 32'd0);

        // Table-driven sequences
        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("row%0d_ready", i), 32'(ready_o), 32'(tbl[i].exp_ready));
            check($sformatf("row%0d_v0", i), 32'(v0_o), 32'(tbl[i].exp_v0));
            check($sformatf("row%0d_v1", i), 32'(v1_o), 32'(tbl[i].exp_v1));
            drive_cycle(tbl[i].data, tbl[i].sel, tbl[i].v, tbl[i].y0, tbl[i].y1);
        end
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        // Reset with buffered words: ch0 holds 2, ch1 holds 1
        drive_cycle(5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check("full_ready", 32'(ready_o), 32'd0);
        check("full_v0", 32'(v0_o), 32'd1);
        check("full_v1", 32'(v1_o), 32'd1);
        reset_i = 1'b1;
        step();
        check("midreset_ready", 32'(ready_o), 32'd0);
        check("midreset_v0", 32'(v0_o), 32'd0);
        check("midreset_v1", 32'(v1_o), 32'd0);
        reset_i = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("release_ready", 32'(ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("no_stale_v0", 32'(v0_o), 32'd0);
            check("no_stale_v1", 32'(v1_o), 32'd0);
            step();
        end

        // Non-inverting variant
        check("ni_ready", 32'(ni_ready), 32'd1);
        ni_data = 5'b00011;
        ni_sel  = 1'b1;
        ni_v    = 1'b1;
        step();
        ni_v = 1'b0;
        check("ni_v1", 32'(ni_v1), 32'd1);
        check("ni_data1", 32'(ni_data1), 32'(5'b00011));
        check("ni_v0", 32'(ni_v0), 32'd0);
        ni_yumi1 = 1'b1;
        step();
        ni_yumi1 = 1'b0;
        check("ni_v1_after_yumi", 32'(ni_v1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if something stalls the sequence
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
